// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/writeback sequencing with strobes.
// Optional macro CTRL_ILLEGAL_TRAP_EN sends illegal opcodes to a sticky TRAP state instead of a NOP.
module cpu_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] instr_op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] opcode_q,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src_br,
    output logic       pc_src_j,
    output logic       reg_we,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t     r_state;
    logic [3:0] r_opcode;

    logic w_isLd, w_isSt, w_isRtype, w_isBeq, w_isBne, w_isJmp, w_isHlt, w_isIllegal;
    logic w_brTaken;

    assign w_isLd      = (r_opcode == 4'b0000);
    assign w_isSt      = (r_opcode == 4'b0001);
    assign w_isRtype   = (r_opcode >= 4'b0010) && (r_opcode <= 4'b1001);
    assign w_isBeq     = (r_opcode == 4'b1010);
    assign w_isBne     = (r_opcode == 4'b1011);
    assign w_isJmp     = (r_opcode == 4'b1100);
    assign w_isHlt     = (r_opcode == 4'b1111);
    assign w_isIllegal = (r_opcode == 4'b1101) || (r_opcode == 4'b1110);
    assign w_brTaken   = (w_isBeq && zero) || (w_isBne && !zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_opcode <= 4'b0000;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_opcode <= instr_op;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_isHlt)
                        r_state <= S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    else if (w_isIllegal)
                        r_state <= S_TRAP;
`endif
                    else
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_isRtype)
                        r_state <= S_WB;
                    else if (w_isLd || w_isSt)
                        r_state <= S_MEM;
                    else
                        r_state <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready)
                        r_state <= w_isLd ? S_WB : S_FETCH;
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP:  r_state <= S_TRAP;
`endif
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them without waiting for an edge.
    always_comb begin
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src_br  = 1'b0;
        pc_src_j   = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_rd = 1'b1;
                alu_op = 2'b10;
                ir_we  = mem_ready;
                pc_we  = mem_ready;
            end
            S_EXEC: begin
                if (w_isLd || w_isSt) begin
                    alu_op  = 2'b10;
                    alu_src = 1'b1;
                end else if (w_isBeq || w_isBne) begin
                    alu_op    = 2'b01;
                    pc_we     = w_brTaken;
                    pc_src_br = w_brTaken;
                    retire    = 1'b1;
                end else if (w_isJmp) begin
                    pc_we    = 1'b1;
                    pc_src_j = 1'b1;
                    retire   = 1'b1;
                end else if (w_isIllegal) begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                mem_rd = w_isLd;
                mem_wr = w_isSt;
                retire = w_isSt && mem_ready;
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = w_isLd;
                retire     = 1'b1;
            end
            S_HALT, S_TRAP: halted = 1'b1;
            default: ;
        endcase
    end

    assign opcode_q = r_opcode;
    assign state    = r_state;

endmodule
